// File: rtl/ervp_asynch_register_write_arbiter.sv
// Round-robin arbiter sharing the write port of one toggle-handshake CDC mailbox.
// Holds the registered grant until the mailbox accepts or the requester withdraws.
module ervp_asynch_register_write_arbiter #(
  parameter int NUM_REQUESTER = 4,
  parameter int BW_DATA = 8,
  parameter int BW_COUNT = 16,
  localparam int BW_SOURCE = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1
) (
  input  logic                             clk,
  input  logic                             rstnn,
  input  logic [NUM_REQUESTER-1:0]         req_request,
  input  logic [NUM_REQUESTER*BW_DATA-1:0] req_data,
  output logic [NUM_REQUESTER-1:0]         req_ready,
  input  logic                             wready,
  output logic                             wrequest,
  output logic [BW_DATA-1:0]               wdata,
  output logic [BW_SOURCE-1:0]             wsource,
  output logic                             busy,
  output logic [BW_COUNT-1:0]              transfer_count
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state;
  state_t                 next_state;
  logic [BW_SOURCE-1:0]   grant_idx;
  logic [BW_SOURCE-1:0]   last_idx;
  logic                   transfer;

  // First set request after the last served index, wrapping modulo NUM_REQUESTER
  function automatic logic [BW_SOURCE-1:0] pick_next(
    input logic [NUM_REQUESTER-1:0] req,
    input logic [BW_SOURCE-1:0]     last
  );
    logic [BW_SOURCE-1:0] result;
    logic                 found;
    int                   cand;
    result = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQUESTER; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_REQUESTER) cand = cand - NUM_REQUESTER;
      if (!found && req[cand[BW_SOURCE-1:0]]) begin
        found  = 1'b1;
        result = BW_SOURCE'(cand);
      end
    end
    return result;
  endfunction

  assign transfer = (state == ISSUE) && req_request[grant_idx] && wready;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state          <= IDLE;
      grant_idx      <= '0;
      last_idx       <= BW_SOURCE'(NUM_REQUESTER - 1);
      transfer_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && |req_request) begin
        grant_idx <= pick_next(req_request, last_idx);
      end
      if (transfer) begin
        last_idx       <= grant_idx;
        transfer_count <= transfer_count + BW_COUNT'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req_request) next_state = ISSUE;
      ISSUE:   if (transfer || !req_request[grant_idx]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wrequest  = 1'b0;
    wdata     = '0;
    wsource   = '0;
    busy      = 1'b0;
    req_ready = '0;
    if (state == ISSUE) begin
      busy                 = 1'b1;
      wrequest             = req_request[grant_idx];
      wdata                = req_data[int'(grant_idx)*BW_DATA +: BW_DATA];
      wsource              = grant_idx;
      req_ready[grant_idx] = transfer;
    end
  end

endmodule

// File: tb/tb_ervp_asynch_register_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected {source,data} transfers; a monitor
// pops and compares them whenever the mailbox accepts a write.
module tb_ervp_asynch_register_write_arbiter;

  localparam int NREQ = 4;
  localparam int BWD  = 8;
  localparam int BWC  = 4;
  localparam int BWS  = 2;

  logic                 clk;
  logic                 rstnn;
  logic [NREQ-1:0]      req_request;
  logic [NREQ*BWD-1:0]  req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wready;
  logic                 wrequest;
  logic [BWD-1:0]       wdata;
  logic [BWS-1:0]       wsource;
  logic                 busy;
  logic [BWC-1:0]       transfer_count;

  typedef struct packed {
    logic [BWS-1:0] src;
    logic [BWD-1:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks;
  int   errors;

  ervp_asynch_register_write_arbiter #(
    .NUM_REQUESTER(NREQ),
    .BW_DATA(BWD),
    .BW_COUNT(BWC)
  ) dut (
    .clk(clk),
    .rstnn(rstnn),
    .req_request(req_request),
    .req_data(req_data),
    .req_ready(req_ready),
    .wready(wready),
    .wrequest(wrequest),
    .wdata(wdata),
    .wsource(wsource),
    .busy(busy),
    .transfer_count(transfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic rdy);
    req_request = req;
    wready      = rdy;
  endtask

  task automatic pushExp(input logic [BWS-1:0] src, input logic [BWD-1:0] data);
    exp_t item;
    item.src  = src;
    item.data = data;
    expQ.push_back(item);
  endtask

  // One clock: note who was served, then optionally withdraw those requests
  task automatic tick(input bit dropServed);
    logic [NREQ-1:0] served;
    @(negedge clk);
    served = req_ready;
    @(posedge clk);
    #1;
    if (dropServed) req_request = req_request & ~served;
    #1;
  endtask

  task automatic resetDut();
    rstnn = 1'b0;
    #1;
    checkOutput("rst_wrequest", 32'(wrequest), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
    checkOutput("rst_count", 32'(transfer_count), 32'(0));
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    #1;
  endtask

  task automatic monitorLoop();
    exp_t            item;
    logic [NREQ-1:0] oneHot;
    forever begin
      @(negedge clk);
      if (rstnn) begin
        if (wrequest && wready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_transfer actual src=%0d data=%0h required none", wsource, wdata);
          end else begin
            item   = expQ.pop_front();
            oneHot = NREQ'(1) << item.src;
            checkOutput("sb_wsource", 32'(wsource), 32'(item.src));
            checkOutput("sb_wdata", 32'(wdata), 32'(item.data));
            checkOutput("sb_req_ready", 32'(req_ready), 32'(oneHot));
          end
        end else begin
          checkOutput("req_ready_quiet", 32'(req_ready), 32'(0));
        end
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rstnn       = 1'b1;
    req_request = '0;
    wready      = 1'b0;
    req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    fork
      monitorLoop();
    join_none
    #1;

    // Reset release with no requests
    resetDut();
    for (int k = 0; k < 10; k++) begin
      tick(1'b0);
      checkOutput("idle_wrequest", 32'(wrequest), 32'(0));
      checkOutput("idle_busy", 32'(busy), 32'(0));
      checkOutput("idle_count", 32'(transfer_count), 32'(0));
    end

    // Single transfer from requester 0
    req_data[7:0] = 8'hA5;
    pushExp(2'd0, 8'hA5);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("t2_wrequest_early", 32'(wrequest), 32'(0));
    tick(1'b1);
    checkOutput("t2_wrequest", 32'(wrequest), 32'(1));
    checkOutput("t2_wsource", 32'(wsource), 32'(0));
    checkOutput("t2_wdata", 32'(wdata), 32'h0A5);
    checkOutput("t2_busy", 32'(busy), 32'(1));
    tick(1'b1);
    checkOutput("t2_wrequest_after", 32'(wrequest), 32'(0));
    checkOutput("t2_busy_after", 32'(busy), 32'(0));
    checkOutput("t2_count", 32'(transfer_count), 32'(1));
    req_data[7:0] = 8'h10;

    // Four continuous requesters: round-robin 0,1,2,3,0,1
    resetDut();
    for (int k = 0; k < 6; k++) pushExp(BWS'(k % 4), BWD'(16 + (k % 4)));
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 12; k++) tick(1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t3_count", 32'(transfer_count), 32'(6));
    checkOutput("t3_queue_empty", 32'(expQ.size()), 32'(0));

    // Grant to 2 held while wready is low, then 3 and 0 follow
    applyStimulus(4'b1101, 1'b0);
    tick(1'b1);
    for (int k = 0; k < 20; k++) begin
      checkOutput("t4_hold_wsource", 32'(wsource), 32'(2));
      checkOutput("t4_hold_busy", 32'(busy), 32'(1));
      tick(1'b1);
    end
    pushExp(2'd2, 8'h12);
    pushExp(2'd3, 8'h13);
    pushExp(2'd0, 8'h10);
    wready = 1'b1;
    for (int k = 0; k < 6; k++) tick(1'b1);
    checkOutput("t4_count", 32'(transfer_count), 32'(9));
    checkOutput("t4_queue_empty", 32'(expQ.size()), 32'(0));

    // Requester 1 withdraws before wready; priority order unchanged
    applyStimulus(4'b0010, 1'b0);
    tick(1'b1);
    checkOutput("t5_busy", 32'(busy), 32'(1));
    checkOutput("t5_wsource", 32'(wsource), 32'(1));
    applyStimulus(4'b0000, 1'b0);
    tick(1'b1);
    checkOutput("t5_busy_after", 32'(busy), 32'(0));
    checkOutput("t5_count", 32'(transfer_count), 32'(9));
    pushExp(2'd1, 8'h11);
    pushExp(2'd3, 8'h13);
    applyStimulus(4'b1010, 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b1);
    checkOutput("t5_count_final", 32'(transfer_count), 32'(11));
    checkOutput("t5_queue_empty", 32'(expQ.size()), 32'(0));

    // Counter wrap: 17 transfers on a 4-bit counter reads 1
    resetDut();
    for (int k = 0; k < 17; k++) pushExp(2'd0, 8'h10);
    applyStimulus(4'b0001, 1'b1);
    for (int k = 0; k < 34; k++) tick(1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t6_count_wrap", 32'(transfer_count), 32'(1));
    checkOutput("t6_queue_empty", 32'(expQ.size()), 32'(0));

    // Reset mid-ISSUE aborts immediately; next grant goes to requester 0
    applyStimulus(4'b0100, 1'b0);
    tick(1'b1);
    checkOutput("t7_busy", 32'(busy), 32'(1));
    checkOutput("t7_wsource", 32'(wsource), 32'(2));
    checkOutput("t7_wdata", 32'(wdata), 32'h012);
    rstnn = 1'b0;
    #1;
    checkOutput("t7_rst_wrequest", 32'(wrequest), 32'(0));
    checkOutput("t7_rst_busy", 32'(busy), 32'(0));
    checkOutput("t7_rst_req_ready", 32'(req_ready), 32'(0));
    checkOutput("t7_rst_wdata", 32'(wdata), 32'(0));
    checkOutput("t7_rst_wsource", 32'(wsource), 32'(0));
    checkOutput("t7_rst_count", 32'(transfer_count), 32'(0));
    pushExp(2'd0, 8'h10);
    pushExp(2'd2, 8'h12);
    applyStimulus(4'b0101, 1'b1);
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) tick(1'b1);
    checkOutput("t7_count", 32'(transfer_count), 32'(2));
    checkOutput("t7_queue_empty", 32'(expQ.size()), 32'(0));

    tick(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
